instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/risc_pkg.sv | 22 ++
 rtl/instr_rom_16x16.sv | 37 +++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared fetch-unit state encoding, opcode constants and instruction field positions
package risc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } ifu_state_t;

    localparam logic [3:0] HALT_OPCODE = 4'hE;
    localparam logic [3:0] JMP_OPCODE  = 4'hF;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OP1_MSB = 11;
    localparam int OP1_LSB = 8;
    localparam int OP2_MSB = 7;
    localparam int OP2_LSB = 0;

endpackage

// File: rtl/instr_rom_16x16.sv
// rtl/instr_rom_16x16.sv - instruction memory, registered read, synchronous write, asynchronous clear
module instr_rom_16x16
    import risc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // rdata doubles as the fetch unit's instruction register, so it only moves on re
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - two-cycle instruction fetch/issue sequencer; IFU_JUMP_EN adds the jump opcode
module instr_fetch_unit
    import risc_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter int         PC_W    = 4,
    parameter logic [3:0] HALT_OP = HALT_OPCODE,
    parameter logic [3:0] JMP_OP  = JMP_OPCODE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [15:0]     prog_data,
    output logic [3:0]      opcode,
    output logic [3:0]      operand_1,
    output logic [7:0]      operand_2,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

`ifdef IFU_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    ifu_state_t         state;
    ifu_state_t         state_nxt;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_nxt;
    logic [INSTR_W-1:0] ir;
    logic               rom_re;
    logic               rom_we;
    logic               is_halt;
    logic               is_jmp;

    assign opcode    = ir[OPC_MSB:OPC_LSB];
    assign operand_1 = ir[OP1_MSB:OP1_LSB];
    assign operand_2 = ir[OP2_MSB:OP2_LSB];
    assign pc        = pc_q;
    assign is_halt   = (opcode == HALT_OP);
    assign is_jmp    = JUMP_EN && (opcode == JMP_OP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (is_jmp) begin
                    state_nxt = ST_FETCH;
                end else if (!stall) begin
                    state_nxt = is_halt ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT:  if (start) state_nxt = ST_FETCH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // memory writes are only honoured while no fetch can be in flight
    always_comb begin
        rom_re      = 1'b0;
        rom_we      = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        pc_nxt      = pc_q;
        case (state)
            ST_IDLE: begin
                rom_we = prog_we;
                if (start) pc_nxt = '0;
            end
            ST_FETCH: rom_re = 1'b1;
            ST_ISSUE: begin
                if (is_jmp) begin
                    pc_nxt = operand_2[PC_W-1:0];
                end else begin
                    instr_valid = 1'b1;
                    if (!stall && !is_halt) pc_nxt = pc_q + PC_W'(1);
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                rom_we = prog_we;
                if (start) pc_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_nxt;
        end
    end

    instr_rom_16x16 #(
        .DEPTH(DEPTH),
        .AW   (PC_W)
    ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .we   (rom_we),
        .waddr(prog_addr),
        .wdata(prog_data),
        .re   (rom_re),
        .raddr(pc_q),
        .rdata(ir)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit against a program-level issue model
module tb_instr_fetch_unit;

`ifdef IFU_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic [3:0]  opcode;
    logic [3:0]  operand_1;
    logic [7:0]  operand_2;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [15:0] ref_mem [16];

    typedef struct packed {
        logic [3:0]  pc;
        logic [15:0] ins;
    } issue_t;

    issue_t exp_q[$];

    instr_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .opcode     (opcode),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .instr_valid(instr_valid),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        start   = 1'b0;
        stall   = 1'b0;
        prog_we = 1'b0;
        rst     = 1'b1;
        #1;
        chk("reset_outputs", {16'h0, opcode, operand_1, operand_2, instr_valid, halted, pc}, 32'h0);
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
        tick;
        rst = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick;
        prog_we   = 1'b0;
        ref_mem[a] = d;
    endtask

    // program semantics: issue mem[pc], stop after halt, jumps redirect silently when enabled
    task automatic build_queue(input int max);
        logic [3:0]  p;
        logic [15:0] w;
        int          steps;
        exp_q.delete();
        p = 4'h0;
        steps = 0;
        while (exp_q.size() < max && steps < 64) begin
            w = ref_mem[p];
            steps++;
            if (JEN && w[15:12] == 4'hF) begin
                p = w[3:0];
            end else begin
                exp_q.push_back({p, w});
                if (w[15:12] == 4'hE) break;
                p = p + 4'h1;
            end
        end
    endtask

    task automatic run(input int max, input int stall_pct, input int stall_pc, input string tag);
        int         accepted;
        int         cyc;
        int         first_valid;
        int         held;
        int         budget;
        int         qsize;
        logic       prev_acc;
        logic [3:0] prev_pc;
        issue_t     hd;
        build_queue(max);
        qsize = exp_q.size();
        accepted = 0;
        cyc = 1;
        first_valid = -1;
        held = 0;
        prev_acc = 1'b0;
        prev_pc = 4'h0;
        budget = max * 30 + 40;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, "_fetch0"}, {26'h0, instr_valid, halted, pc}, 32'h0);
        while (accepted < qsize && cyc < budget) begin
            if (prev_acc) begin
                chk({tag, "_gap"}, {31'h0, instr_valid}, 32'h0);
                chk({tag, "_next_pc"}, {28'h0, pc}, {28'h0, 4'(prev_pc + 4'h1)});
            end
            if (instr_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    chk({tag, "_latency"}, first_valid, 2);
                end
                hd = exp_q[accepted];
                chk({tag, "_issue"}, {12'h0, pc, opcode, operand_1, operand_2}, {12'h0, hd.pc, hd.ins});
                if (stall_pc >= 0) begin
                    stall = (int'(pc) == stall_pc) && (held < 3);
                    if (stall) held++;
                end else begin
                    stall = ($urandom_range(0, 99) < stall_pct);
                end
            end else begin
                stall = (stall_pc < 0) && ($urandom_range(0, 99) < stall_pct);
            end
            start = (stall_pct > 0) && ($urandom_range(0, 7) == 0);
            prev_acc = instr_valid && !stall;
            prev_pc = pc;
            if (prev_acc) accepted++;
            tick;
            cyc++;
        end
        start = 1'b0;
        stall = 1'b0;
        chk({tag, "_all_issued"}, accepted, qsize);
        if (stall_pc >= 0) chk({tag, "_stall_held"}, held, 3);
        if (qsize > 0 && exp_q[qsize-1].ins[15:12] == 4'hE) begin
            for (int k = 0; k < 3; k++) begin
                chk({tag, "_halted"}, {26'h0, halted, instr_valid, pc}, {26'h0, 1'b1, 1'b0, exp_q[qsize-1].pc});
                tick;
            end
        end
    endtask

    initial begin
        int n;
        rst       = 1'b0;
        start     = 1'b0;
        stall     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = 4'h0;
        prog_data = 16'h0;
        #2;
        do_reset;

        write_word(4'h0, 16'h1203);
        write_word(4'h1, 16'h2405);
        write_word(4'h2, 16'hE000);
        run(8, 0, -1, "basic");
        run(8, 0, 1, "stall");

        do_reset;
        for (int i = 0; i < 16; i++) write_word(4'(i), 16'h1000);
        run(20, 25, -1, "wrap");

        do_reset;
        write_word(4'h0, 16'h1203);
        write_word(4'h1, 16'hF009);
        write_word(4'h9, 16'hE000);
        run(12, 0, -1, "jump");

        // writes attempted while a fetch is in flight must not land
        do_reset;
        write_word(4'h0, 16'h1203);
        write_word(4'h1, 16'h2405);
        write_word(4'h2, 16'hE000);
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (!instr_valid && n < 10) begin tick; n++; end
        chk("ro_wait_valid", {31'h0, instr_valid}, 32'h1);
        prog_we   = 1'b1;
        prog_addr = 4'h2;
        prog_data = 16'h1111;
        tick;
        tick;
        prog_we = 1'b0;
        n = 0;
        while (!halted && n < 20) begin tick; n++; end
        chk("ro_halt_pc", {27'h0, halted, pc}, {27'h0, 1'b1, 4'h2});
        write_word(4'h0, 16'h3ABC);
        write_word(4'h1, 16'hE055);
        run(8, 0, -1, "restart");

        // reset during issue aborts and clears memory
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (!instr_valid && n < 10) begin tick; n++; end
        chk("rst_wait_valid", {31'h0, instr_valid}, 32'h1);
        #2;
        do_reset;
        for (int k = 0; k < 2; k++) begin
            chk("rst_idle", {26'h0, instr_valid, halted, pc}, 32'h0);
            tick;
        end
        run(3, 0, -1, "cleared");

        for (int it = 0; it < 6; it++) begin
            logic [15:0] w;
            do_reset;
            for (int i = 0; i < 16; i++) begin
                w = 16'($urandom);
                w[15:12] = 4'($urandom_range(0, 14));
                write_word(4'(i), w);
            end
            run(24, 30, -1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
